ahb_slave_pipe: RTL and testbench

// AHB-side front end of the AHB-to-APB bridge. It sits between the AHB master
// (driven through the AHB interface) and the APB FSM controller.
// - Pipelines the address, data and direction of each transfer.
// - Decodes the peripheral select and generates transfer-valid.
// - Tracks fixed-length bursts and flags protocol errors.
// - Produces the two-cycle AHB ERROR response for unmapped addresses.

---
 rtl/ahb_slave_pipe.sv | 173 +++++++++++++++++
 tb/tb_ahb_slave_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_pipe.sv
// rtl/ahb_slave_pipe.sv - AHB-side front end of the AHB-to-APB bridge
// Pipelines accepted transfers, decodes the peripheral select, tracks bursts and drives ERROR.

module ahb_slave_pipe #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLV1_BASE = 32'h8400_0000,
  parameter logic [ADDR_W-1:0] SLV2_BASE = 32'h8800_0000,
  parameter logic [ADDR_W-1:0] SLV_SIZE  = 32'h0400_0000
) (
  input  logic              clock,
  input  logic              Hresetn,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [2:0]        Hsize,
  input  logic [2:0]        Hburst,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  output logic              valid,
  output logic [ADDR_W-1:0] Haddr1,
  output logic [ADDR_W-1:0] Haddr2,
  output logic [DATA_W-1:0] Hwdata1,
  output logic [DATA_W-1:0] Hwdata2,
  output logic              Hwritereg,
  output logic [2:0]        tempselx,
  output logic [1:0]        Hresp,
  output logic              Hready_err,
  output logic              burst_err
);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [2:0] B_INCR   = 3'b001;

  typedef enum logic [1:0] {E_OK, E_ERR1, E_ERR2} err_state_t;
  typedef enum logic       {B_IDLE, B_BURST} burst_state_t;

  err_state_t        estate, estate_nxt;
  burst_state_t      bstate, bstate_nxt;
  logic [4:0]        cnt, cnt_nxt, load_cnt;
  logic [2:0]        hburst_r, hburst_nxt;
  logic              incr_open, incr_nxt;
  logic [ADDR_W-1:0] prev_addr, prev_nxt;
  logic              berr_nxt;
  logic              acc, mapped, take;
  logic [ADDR_W-1:0] nbeats, size_bytes, incr_addr, wrap_mask, exp_addr;
  logic              seq_bad;

  // Upper bound evaluated one bit wider so a region ending at the top of the map still decodes.
  function automatic logic in_rgn(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] base);
    logic [ADDR_W:0] lim;
    lim = {1'b0, base} + {1'b0, SLV_SIZE};
    return (a >= base) && ({1'b0, a} < lim);
  endfunction

  assign tempselx = {in_rgn(Haddr, SLV2_BASE), in_rgn(Haddr, SLV1_BASE), in_rgn(Haddr, SLV0_BASE)};
  assign acc      = Hreadyin && Htrans[1];
  assign mapped   = |tempselx;
  assign valid    = Hresetn && acc && mapped;
  assign take     = acc && (estate != E_ERR1);

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      Haddr1    <= '0;
      Haddr2    <= '0;
      Hwdata1   <= '0;
      Hwdata2   <= '0;
      Hwritereg <= 1'b0;
    end else if (Hreadyin) begin
      Haddr1    <= Haddr;
      Haddr2    <= Haddr1;
      Hwdata1   <= Hwdata;
      Hwdata2   <= Hwdata1;
      Hwritereg <= Hwrite;
    end
  end

  always_comb begin
    estate_nxt = estate;
    case (estate)
      E_OK:    if (acc && !mapped) estate_nxt = E_ERR1;
      E_ERR1:  estate_nxt = E_ERR2;
      default: estate_nxt = E_OK;
    endcase
  end

  assign Hresp      = (estate != E_OK) ? 2'b01 : 2'b00;
  assign Hready_err = (estate != E_ERR1);

  always_comb begin
    case (Hburst[2:1])
      2'd1:    load_cnt = 5'd3;
      2'd2:    load_cnt = 5'd7;
      2'd3:    load_cnt = 5'd15;
      default: load_cnt = 5'd0;
    endcase
    case (hburst_r[2:1])
      2'd1:    nbeats = ADDR_W'(4);
      2'd2:    nbeats = ADDR_W'(8);
      default: nbeats = ADDR_W'(16);
    endcase
  end

  // Odd burst codes increment; even codes wrap on an (nbeats << Hsize) boundary.
  assign size_bytes = ADDR_W'(1) << Hsize;
  assign incr_addr  = prev_addr + size_bytes;
  assign wrap_mask  = (nbeats << Hsize) - ADDR_W'(1);
  assign exp_addr   = hburst_r[0] ? incr_addr : ((prev_addr & ~wrap_mask) | (incr_addr & wrap_mask));
  assign seq_bad    = (Hburst != hburst_r) || (Haddr != exp_addr);

  always_comb begin
    bstate_nxt = bstate;
    cnt_nxt    = cnt;
    hburst_nxt = hburst_r;
    incr_nxt   = incr_open;
    prev_nxt   = prev_addr;
    berr_nxt   = 1'b0;
    if (take) begin
      if (!mapped) begin
        bstate_nxt = B_IDLE;
        cnt_nxt    = 5'd0;
        incr_nxt   = 1'b0;
      end else begin
        prev_nxt = Haddr;
        if (Htrans == T_NONSEQ) begin
          berr_nxt   = (bstate == B_BURST) && (cnt != 5'd0);
          hburst_nxt = Hburst;
          incr_nxt   = (Hburst == B_INCR);
          if (load_cnt != 5'd0) begin
            bstate_nxt = B_BURST;
            cnt_nxt    = load_cnt;
          end else begin
            bstate_nxt = B_IDLE;
            cnt_nxt    = 5'd0;
          end
        end else if (bstate == B_BURST) begin
          berr_nxt = seq_bad;
          cnt_nxt  = cnt - 5'd1;
          if (cnt == 5'd1) bstate_nxt = B_IDLE;
        end else if (incr_open) begin
          berr_nxt = seq_bad;
        end else begin
          berr_nxt = 1'b1;
        end
      end
    end else if (Hreadyin && Htrans == T_IDLE) begin
      incr_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      estate    <= E_OK;
      bstate    <= B_IDLE;
      cnt       <= 5'd0;
      hburst_r  <= 3'd0;
      incr_open <= 1'b0;
      prev_addr <= '0;
      burst_err <= 1'b0;
    end else begin
      estate    <= estate_nxt;
      bstate    <= bstate_nxt;
      cnt       <= cnt_nxt;
      hburst_r  <= hburst_nxt;
      incr_open <= incr_nxt;
      prev_addr <= prev_nxt;
      burst_err <= berr_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_slave_pipe.sv
// tb/tb_ahb_slave_pipe.sv - self-checking bench for ahb_slave_pipe
// Directed vector table, async reset sequence, then randomized traffic against a reference model.

module tb_ahb_slave_pipe;

  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;

  logic        clock = 1'b0;
  logic        Hresetn, Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize, Hburst;
  logic [31:0] Haddr, Hwdata;
  logic        valid, Hwritereg, Hready_err, burst_err;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2;
  logic [2:0]  tempselx;
  logic [1:0]  Hresp;

  always #5 clock = ~clock;

  ahb_slave_pipe dut (
    .clock(clock), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Hsize(Hsize), .Hburst(Hburst), .Haddr(Haddr), .Hwdata(Hwdata),
    .valid(valid), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1), .Hwdata2(Hwdata2),
    .Hwritereg(Hwritereg), .tempselx(tempselx), .Hresp(Hresp), .Hready_err(Hready_err),
    .burst_err(burst_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  tr;   logic [2:0]  bu;   logic [31:0] addr; logic wr; logic [31:0] wd; logic rdy;
    logic        v;    logic [2:0]  sel;  logic [1:0]  resp; logic rerr; logic be;
    logic [31:0] a1;   logic [31:0] d1;   logic        w;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] addr,
                              input logic wr, input logic [31:0] wd, input logic rdy,
                              input logic v, input logic [2:0] sel, input logic [1:0] resp,
                              input logic rerr, input logic be, input logic [31:0] a1,
                              input logic [31:0] d1, input logic w);
    vec_t r;
    r.tr = tr; r.bu = bu; r.addr = addr; r.wr = wr; r.wd = wd; r.rdy = rdy;
    r.v = v; r.sel = sel; r.resp = resp; r.rerr = rerr; r.be = be; r.a1 = a1; r.d1 = d1; r.w = w;
    return r;
  endfunction

  // Reference model state: history of accepted cycles and abstract burst/error bookkeeping.
  logic [31:0] qa[$], qd[$];
  logic        m_w1, m_be;
  int          err_left, beats_left;
  logic [2:0]  kind;
  logic        incr_open;
  logic [31:0] prev;
  logic [31:0] edges[5];

  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    longint unsigned x;
    x = a;
    if (x >= 64'h8000_0000 && x < 64'h8C00_0000) return 3'b001 << ((x - 64'h8000_0000) / 64'h0400_0000);
    return 3'b000;
  endfunction

  function automatic logic [31:0] exp_next(input logic [31:0] p, input logic [2:0] k, input logic [2:0] sz);
    logic [31:0] sb, bound;
    sb = 32'd1 << sz;
    if (k[0]) return p + sb;
    bound = (32'd4 << ((k >> 1) - 1)) << sz;
    return p - (p % bound) + ((p + sb) % bound);
  endfunction

  task automatic model_reset();
    qa = {32'd0, 32'd0}; qd = {32'd0, 32'd0};
    m_w1 = 0; m_be = 0; err_left = 0; beats_left = 0; kind = 0; incr_open = 0; prev = 0;
  endtask

  task automatic model_step();
    logic acc, mapped, ignored, be_new;
    acc = Hreadyin && Htrans[1];
    mapped = (ref_sel(Haddr) != 0);
    ignored = (err_left == 2);
    be_new = 0;
    if (acc && !ignored) begin
      if (!mapped) begin
        beats_left = 0; incr_open = 0;
      end else if (Htrans == NS) begin
        be_new = (beats_left > 0);
        kind = Hburst;
        incr_open = (Hburst == 3'd1);
        beats_left = (Hburst >= 3'd2) ? (4 << ((Hburst >> 1) - 1)) - 1 : 0;
        prev = Haddr;
      end else begin
        if (beats_left > 0 || incr_open) begin
          be_new = (Hburst != kind) || (Haddr != exp_next(prev, kind, Hsize));
          if (beats_left > 0) beats_left--;
        end else begin
          be_new = 1;
        end
        prev = Haddr;
      end
    end else if (Hreadyin && Htrans == IDL) begin
      incr_open = 0;
    end
    if (err_left > 0) err_left--;
    else if (acc && !mapped) err_left = 2;
    m_be = be_new;
    if (Hreadyin) begin
      qa.push_front(Haddr); void'(qa.pop_back());
      qd.push_front(Hwdata); void'(qd.pop_back());
      m_w1 = Hwrite;
    end
  endtask

  task automatic drive(input logic [1:0] tr, input logic [2:0] bu, input logic [2:0] sz,
                       input logic [31:0] addr, input logic wr, input logic [31:0] wd, input logic rdy);
    Htrans = tr; Hburst = bu; Hsize = sz; Haddr = addr; Hwrite = wr; Hwdata = wd; Hreadyin = rdy;
  endtask

  vec_t tbl[$];

  initial begin
    edges[0] = 32'h7FFF_FFFC; edges[1] = 32'h83FF_FFFC; edges[2] = 32'h8400_0000;
    edges[3] = 32'h8BFF_FFFC; edges[4] = 32'h8C00_0000;

    tbl.push_back(mk(NS,  3'd0, 32'h8000_0010, 1, 32'h0,         1, 1, 3'b001, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'hA5A5_0001, 1, 0, 3'b000, 0, 1, 0, 32'h8000_0010, 32'h0,         1));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         1, 0, 3'b000, 0, 1, 0, 32'h0,         32'hA5A5_0001, 0));
    tbl.push_back(mk(NS,  3'd3, 32'h8400_0000, 1, 32'h0,         1, 1, 3'b010, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(SQ,  3'd3, 32'h8400_0004, 1, 32'h1,         1, 1, 3'b010, 0, 1, 0, 32'h8400_0000, 32'h0,         1));
    tbl.push_back(mk(SQ,  3'd3, 32'h8400_0008, 1, 32'h2,         1, 1, 3'b010, 0, 1, 0, 32'h8400_0004, 32'h1,         1));
    tbl.push_back(mk(SQ,  3'd3, 32'h8400_000C, 1, 32'h3,         1, 1, 3'b010, 0, 1, 0, 32'h8400_0008, 32'h2,         1));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h4,         1, 0, 3'b000, 0, 1, 0, 32'h8400_000C, 32'h3,         1));
    tbl.push_back(mk(SQ,  3'd3, 32'h8400_0010, 0, 32'h0,         1, 1, 3'b010, 0, 1, 0, 32'h0,         32'h4,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         1, 0, 3'b000, 0, 1, 1, 32'h8400_0010, 32'h0,         0));
    tbl.push_back(mk(NS,  3'd2, 32'h8800_0008, 0, 32'h0,         1, 1, 3'b100, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(SQ,  3'd2, 32'h8800_000C, 0, 32'h0,         1, 1, 3'b100, 0, 1, 0, 32'h8800_0008, 32'h0,         0));
    tbl.push_back(mk(SQ,  3'd2, 32'h8800_0000, 0, 32'h0,         1, 1, 3'b100, 0, 1, 0, 32'h8800_000C, 32'h0,         0));
    tbl.push_back(mk(SQ,  3'd2, 32'h8800_0004, 0, 32'h0,         1, 1, 3'b100, 0, 1, 0, 32'h8800_0000, 32'h0,         0));
    tbl.push_back(mk(NS,  3'd2, 32'h8800_0008, 0, 32'h0,         1, 1, 3'b100, 0, 1, 0, 32'h8800_0004, 32'h0,         0));
    tbl.push_back(mk(SQ,  3'd2, 32'h8800_000C, 0, 32'h0,         1, 1, 3'b100, 0, 1, 0, 32'h8800_0008, 32'h0,         0));
    tbl.push_back(mk(SQ,  3'd2, 32'h8800_0010, 0, 32'h0,         1, 1, 3'b100, 0, 1, 0, 32'h8800_000C, 32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         1, 0, 3'b000, 0, 1, 1, 32'h8800_0010, 32'h0,         0));
    tbl.push_back(mk(NS,  3'd0, 32'h8800_0020, 0, 32'h0,         1, 1, 3'b100, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         1, 0, 3'b000, 0, 1, 1, 32'h8800_0020, 32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         1, 0, 3'b000, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(NS,  3'd0, 32'h9000_0000, 0, 32'h0,         1, 0, 3'b000, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         0, 0, 3'b000, 1, 0, 0, 32'h9000_0000, 32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         1, 0, 3'b000, 1, 1, 0, 32'h9000_0000, 32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         1, 0, 3'b000, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(NS,  3'd0, 32'h8000_0000, 0, 32'h0,         0, 0, 3'b001, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         1, 0, 3'b000, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(NS,  3'd5, 32'h8000_0100, 0, 32'h0,         1, 1, 3'b001, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(SQ,  3'd5, 32'h8000_0104, 0, 32'h0,         1, 1, 3'b001, 0, 1, 0, 32'h8000_0100, 32'h0,         0));
    tbl.push_back(mk(SQ,  3'd5, 32'h8000_0108, 0, 32'h0,         1, 1, 3'b001, 0, 1, 0, 32'h8000_0104, 32'h0,         0));
    tbl.push_back(mk(NS,  3'd3, 32'h8000_0200, 0, 32'h0,         1, 1, 3'b001, 0, 1, 0, 32'h8000_0108, 32'h0,         0));
    tbl.push_back(mk(SQ,  3'd3, 32'h8000_0204, 0, 32'h0,         1, 1, 3'b001, 0, 1, 1, 32'h8000_0200, 32'h0,         0));
    tbl.push_back(mk(SQ,  3'd3, 32'h8000_0208, 0, 32'h0,         1, 1, 3'b001, 0, 1, 0, 32'h8000_0204, 32'h0,         0));
    tbl.push_back(mk(SQ,  3'd3, 32'h8000_020C, 0, 32'h0,         1, 1, 3'b001, 0, 1, 0, 32'h8000_0208, 32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         1, 0, 3'b000, 0, 1, 0, 32'h8000_020C, 32'h0,         0));
    tbl.push_back(mk(SQ,  3'd3, 32'h8000_0210, 0, 32'h0,         1, 1, 3'b001, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         1, 0, 3'b000, 0, 1, 1, 32'h8000_0210, 32'h0,         0));
    tbl.push_back(mk(NS,  3'd3, 32'h8000_0300, 0, 32'h0,         1, 1, 3'b001, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(SQ,  3'd3, 32'h9000_0304, 0, 32'h0,         1, 0, 3'b000, 0, 1, 0, 32'h8000_0300, 32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         0, 0, 3'b000, 1, 0, 0, 32'h9000_0304, 32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         1, 0, 3'b000, 1, 1, 0, 32'h9000_0304, 32'h0,         0));
    tbl.push_back(mk(SQ,  3'd3, 32'h8000_0308, 0, 32'h0,         1, 1, 3'b001, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(IDL, 3'd0, 32'h0,         0, 32'h0,         1, 0, 3'b000, 0, 1, 1, 32'h8000_0308, 32'h0,         0));

    Hresetn = 1'b0;
    drive(IDL, 3'd0, 3'd2, 32'h0, 1'b0, 32'h0, 1'b1);
    repeat (2) @(posedge clock);
    #1 Hresetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].tr, tbl[i].bu, 3'd2, tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].rdy);
      #3;
      chk($sformatf("vec%0d_valid", i),      valid,      tbl[i].v);
      chk($sformatf("vec%0d_tempselx", i),   tempselx,   tbl[i].sel);
      chk($sformatf("vec%0d_hresp", i),      Hresp,      tbl[i].resp);
      chk($sformatf("vec%0d_hready_err", i), Hready_err, tbl[i].rerr);
      chk($sformatf("vec%0d_burst_err", i),  burst_err,  tbl[i].be);
      chk($sformatf("vec%0d_haddr1", i),     Haddr1,     tbl[i].a1);
      chk($sformatf("vec%0d_hwdata1", i),    Hwdata1,    tbl[i].d1);
      chk($sformatf("vec%0d_hwritereg", i),  Hwritereg,  tbl[i].w);
      @(posedge clock);
      #1;
    end

    // Async reset while mid-burst and in the first ERROR cycle, with a mapped write on the bus.
    drive(NS, 3'd5, 3'd2, 32'h8000_0000, 1'b1, 32'hDEAD_0001, 1'b1);
    @(posedge clock); #1;
    drive(SQ, 3'd5, 3'd2, 32'h8000_0004, 1'b1, 32'hDEAD_0002, 1'b1);
    @(posedge clock); #1;
    drive(NS, 3'd0, 3'd2, 32'h9000_0000, 1'b1, 32'hDEAD_0003, 1'b1);
    @(posedge clock); #1;
    drive(NS, 3'd0, 3'd2, 32'h8000_0008, 1'b1, 32'hDEAD_0004, 1'b1);
    chk("pre_reset_hready_err", Hready_err, 1'b0);
    #2 Hresetn = 1'b0;
    #1;
    chk("rst_valid",      valid,      1'b0);
    chk("rst_haddr1",     Haddr1,     32'h0);
    chk("rst_haddr2",     Haddr2,     32'h0);
    chk("rst_hwdata1",    Hwdata1,    32'h0);
    chk("rst_hwdata2",    Hwdata2,    32'h0);
    chk("rst_hwritereg",  Hwritereg,  1'b0);
    chk("rst_hresp",      Hresp,      2'b00);
    chk("rst_hready_err", Hready_err, 1'b1);
    chk("rst_burst_err",  burst_err,  1'b0);
    @(posedge clock); #1;
    chk("rst_hold_haddr1", Haddr1, 32'h0);
    chk("rst_hold_hresp",  Hresp,  2'b00);
    Hresetn = 1'b1;
    model_reset();

    for (int n = 0; n < 3000; n++) begin
      logic [1:0]  tr;
      logic [2:0]  bu, sz;
      logic [31:0] addr;
      int          r;
      r  = $urandom_range(0, 99);
      tr = (r < 15) ? IDL : (r < 25) ? BSY : (r < 50) ? NS : SQ;
      sz = 3'($urandom_range(0, 2));
      bu = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 19);
      if (r == 0)      addr = 32'h9000_0000 + ($urandom_range(0, 15) << 2);
      else if (r == 1) addr = edges[$urandom_range(0, 4)];
      else             addr = 32'h8000_0000 + ($urandom_range(0, 2) * 32'h0400_0000) + ($urandom_range(0, 63) << 2);
      if (tr == SQ && (beats_left > 0 || incr_open) && $urandom_range(0, 9) != 0) begin
        bu   = ($urandom_range(0, 19) == 0) ? bu : kind;
        addr = exp_next(prev, kind, sz);
      end
      drive(tr, bu, sz, addr, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) != 0));
      #3;
      chk("rnd_valid",      valid,      (Hreadyin && Htrans[1] && ref_sel(Haddr) != 0));
      chk("rnd_tempselx",   tempselx,   ref_sel(Haddr));
      chk("rnd_haddr1",     Haddr1,     qa[0]);
      chk("rnd_haddr2",     Haddr2,     qa[1]);
      chk("rnd_hwdata1",    Hwdata1,    qd[0]);
      chk("rnd_hwdata2",    Hwdata2,    qd[1]);
      chk("rnd_hwritereg",  Hwritereg,  m_w1);
      chk("rnd_hresp",      Hresp,      (err_left != 0) ? 2'b01 : 2'b00);
      chk("rnd_hready_err", Hready_err, (err_left != 2));
      chk("rnd_burst_err",  burst_err,  m_be);
      @(posedge clock);
      model_step();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
